// File: rtl/sync_timing_gen_pkg.sv
// Shared video timing constants (default 1280x720p60-style raster) and
// small helpers used by the sync generator and by downstream video consumers.
package sync_timing_gen_pkg;

    // Horizontal timing in pixel clocks
    localparam int unsigned H_ACT_DEF  = 1280;
    localparam int unsigned H_FP_DEF   = 110;
    localparam int unsigned H_SYNC_DEF = 40;
    localparam int unsigned H_BP_DEF   = 220;

    // Vertical timing in lines
    localparam int unsigned V_ACT_DEF  = 720;
    localparam int unsigned V_FP_DEF   = 5;
    localparam int unsigned V_SYNC_DEF = 5;
    localparam int unsigned V_BP_DEF   = 20;

    // Full period of one axis: sync + back porch + active + front porch
    function automatic int unsigned timing_total(input int unsigned sync_len,
                                                 input int unsigned bp_len,
                                                 input int unsigned act_len,
                                                 input int unsigned fp_len);
        return sync_len + bp_len + act_len + fp_len;
    endfunction

    // Counter width able to hold 0..total-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 2) ? $clog2(total) : 1;
    endfunction

    localparam int unsigned H_TOTAL_DEF = timing_total(H_SYNC_DEF, H_BP_DEF, H_ACT_DEF, H_FP_DEF);
    localparam int unsigned V_TOTAL_DEF = timing_total(V_SYNC_DEF, V_BP_DEF, V_ACT_DEF, V_FP_DEF);

    // Per-cycle sync/enable levels before output registering
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
    } sync_flags_t;

endpackage

// File: rtl/sync_region_cnt.sv
// Wrapping position counter for one raster axis with region decode.
// Ports:
//   pix_clk    - pixel clock
//   rst        - synchronous active-high reset, clears the count
//   en         - advance the count this cycle
//   wrap_c     - carry-out: count is at its last value and advancing
//   in_sync_c  - count lies in the sync region
//   in_act_c   - count lies in the active region
//   act_off_c  - count minus the start of the active region
module sync_region_cnt
    import sync_timing_gen_pkg::*;
#(
    parameter int unsigned SYNC_LEN = H_SYNC_DEF,
    parameter int unsigned BP_LEN   = H_BP_DEF,
    parameter int unsigned ACT_LEN  = H_ACT_DEF,
    parameter int unsigned FP_LEN   = H_FP_DEF,
    parameter int unsigned CNT_W    = cnt_width(timing_total(SYNC_LEN, BP_LEN, ACT_LEN, FP_LEN))
) (
    input  logic             pix_clk,
    input  logic             rst,
    input  logic             en,
    output logic             wrap_c,
    output logic             in_sync_c,
    output logic             in_act_c,
    output logic [CNT_W-1:0] act_off_c
);

    localparam int unsigned TOTAL = timing_total(SYNC_LEN, BP_LEN, ACT_LEN, FP_LEN);

    // Region boundaries; inclusive last-active avoids overflow when FP_LEN is 0
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] SYNC_END  = CNT_W'(SYNC_LEN);
    localparam logic [CNT_W-1:0] ACT_FIRST = CNT_W'(SYNC_LEN + BP_LEN);
    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(SYNC_LEN + BP_LEN + ACT_LEN - 1);

    logic [CNT_W-1:0] cnt;

    // Position counter
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= wrap_c ? '0 : cnt + CNT_W'(1);
        end
    end

    // Carry-out and region decode
    always_comb begin
        wrap_c    = en && (cnt == CNT_LAST);
        in_sync_c = (cnt < SYNC_END);
        in_act_c  = (cnt >= ACT_FIRST) && (cnt <= ACT_LAST);
        act_off_c = cnt - ACT_FIRST;
    end

endmodule

// File: rtl/sync_timing_gen.sv
// Video sync timing generator: produces registered hsync/vsync/data-enable,
// active pixel coordinates and line/frame start pulses from one pixel clock.
// Ports:
//   pix_clk     - pixel clock, all logic on its rising edge
//   rst         - synchronous active-high reset
//   hs_out      - horizontal sync (HS_POL while in sync)
//   vs_out      - vertical sync (VS_POL while in sync lines)
//   de_out      - active video enable
//   act_x/act_y - active column/row, zero outside active video
//   line_start  - one-cycle pulse at the first pixel of each line
//   frame_start - one-cycle pulse at the first pixel of each frame
module sync_timing_gen
    import sync_timing_gen_pkg::*;
#(
    parameter int unsigned X_BITS = 13,
    parameter int unsigned Y_BITS = 13,
    parameter int unsigned H_ACT  = H_ACT_DEF,
    parameter int unsigned H_FP   = H_FP_DEF,
    parameter int unsigned H_SYNC = H_SYNC_DEF,
    parameter int unsigned H_BP   = H_BP_DEF,
    parameter int unsigned V_ACT  = V_ACT_DEF,
    parameter int unsigned V_FP   = V_FP_DEF,
    parameter int unsigned V_SYNC = V_SYNC_DEF,
    parameter int unsigned V_BP   = V_BP_DEF,
    parameter bit          HS_POL = 1'b1,
    parameter bit          VS_POL = 1'b1
) (
    input  logic              pix_clk,
    input  logic              rst,
    output logic              hs_out,
    output logic              vs_out,
    output logic              de_out,
    output logic [X_BITS-1:0] act_x,
    output logic [Y_BITS-1:0] act_y,
    output logic              line_start,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL = timing_total(H_SYNC, H_BP, H_ACT, H_FP);
    localparam int unsigned V_TOTAL = timing_total(V_SYNC, V_BP, V_ACT, V_FP);
    localparam int unsigned HC_W    = cnt_width(H_TOTAL);
    localparam int unsigned VC_W    = cnt_width(V_TOTAL);

    logic            h_wrap_c, h_sync_c, h_act_c;
    logic            v_wrap_c, v_sync_c, v_act_c;
    logic [HC_W-1:0] h_off_c;
    logic [VC_W-1:0] v_off_c;
    logic            line_zero, frame_zero;
    sync_flags_t     flags_c;

    // Pixel counter, advances every cycle
    sync_region_cnt #(
        .SYNC_LEN (H_SYNC),
        .BP_LEN   (H_BP),
        .ACT_LEN  (H_ACT),
        .FP_LEN   (H_FP),
        .CNT_W    (HC_W)
    ) u_h_cnt (
        .pix_clk   (pix_clk),
        .rst       (rst),
        .en        (1'b1),
        .wrap_c    (h_wrap_c),
        .in_sync_c (h_sync_c),
        .in_act_c  (h_act_c),
        .act_off_c (h_off_c)
    );

    // Line counter, advances on the pixel counter carry
    sync_region_cnt #(
        .SYNC_LEN (V_SYNC),
        .BP_LEN   (V_BP),
        .ACT_LEN  (V_ACT),
        .FP_LEN   (V_FP),
        .CNT_W    (VC_W)
    ) u_v_cnt (
        .pix_clk   (pix_clk),
        .rst       (rst),
        .en        (h_wrap_c),
        .wrap_c    (v_wrap_c),
        .in_sync_c (v_sync_c),
        .in_act_c  (v_act_c),
        .act_off_c (v_off_c)
    );

    // Flags tracking counter state h==0 and (h,v)==(0,0): set by reset or by the carry into zero
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            line_zero  <= 1'b1;
            frame_zero <= 1'b1;
        end else begin
            line_zero  <= h_wrap_c;
            frame_zero <= v_wrap_c;
        end
    end

    // Sync levels and enable for the current counter state
    always_comb begin
        flags_c    = '0;
        flags_c.hs = h_sync_c ? HS_POL : ~HS_POL;
        flags_c.vs = v_sync_c ? VS_POL : ~VS_POL;
        flags_c.de = h_act_c && v_act_c;
    end

    // Output register: everything lags the counter state by exactly one cycle
    always_ff @(posedge pix_clk) begin
        if (rst) begin
            hs_out      <= ~HS_POL;
            vs_out      <= ~VS_POL;
            de_out      <= 1'b0;
            act_x       <= '0;
            act_y       <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs_out      <= flags_c.hs;
            vs_out      <= flags_c.vs;
            de_out      <= flags_c.de;
            act_x       <= flags_c.de ? X_BITS'(h_off_c) : '0;
            act_y       <= flags_c.de ? Y_BITS'(v_off_c) : '0;
            line_start  <= line_zero;
            frame_start <= frame_zero;
        end
    end

endmodule

// File: tb/tb_sync_timing_gen.sv
// Self-checking bench for sync_timing_gen on a reduced raster (28 x 13),
// with a second instance using inverted sync polarities.
module tb_sync_timing_gen;

    localparam int T_HSYNC = 4;
    localparam int T_HBP   = 5;
    localparam int T_HACT  = 16;
    localparam int T_HFP   = 3;
    localparam int T_VSYNC = 2;
    localparam int T_VBP   = 3;
    localparam int T_VACT  = 6;
    localparam int T_VFP   = 2;
    localparam int T_HTOT  = T_HSYNC + T_HBP + T_HACT + T_HFP;
    localparam int T_VTOT  = T_VSYNC + T_VBP + T_VACT + T_VFP;
    localparam int FRAME   = T_HTOT * T_VTOT;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        ls;
        logic        fs;
        logic [12:0] ax;
        logic [12:0] ay;
    } obs_t;

    typedef struct {
        string name;
        int    cyc;
        obs_t  exp;
    } vec_t;

    logic        pix_clk;
    logic        rst;
    logic        hs_p, vs_p, de_p, ls_p, fs_p;
    logic [12:0] ax_p, ay_p;
    logic        hs_n, vs_n, de_n, ls_n, fs_n;
    logic [12:0] ax_n, ay_n;

    int tests_run    = 0;
    int tests_failed = 0;
    int mpos         = 0;
    vec_t vecs[14];

    sync_timing_gen #(
        .X_BITS(13), .Y_BITS(13),
        .H_ACT(T_HACT), .H_FP(T_HFP), .H_SYNC(T_HSYNC), .H_BP(T_HBP),
        .V_ACT(T_VACT), .V_FP(T_VFP), .V_SYNC(T_VSYNC), .V_BP(T_VBP),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut (
        .pix_clk(pix_clk), .rst(rst), .hs_out(hs_p), .vs_out(vs_p), .de_out(de_p),
        .act_x(ax_p), .act_y(ay_p), .line_start(ls_p), .frame_start(fs_p)
    );

    sync_timing_gen #(
        .X_BITS(13), .Y_BITS(13),
        .H_ACT(T_HACT), .H_FP(T_HFP), .H_SYNC(T_HSYNC), .H_BP(T_HBP),
        .V_ACT(T_VACT), .V_FP(T_VFP), .V_SYNC(T_VSYNC), .V_BP(T_VBP),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_n (
        .pix_clk(pix_clk), .rst(rst), .hs_out(hs_n), .vs_out(vs_n), .de_out(de_n),
        .act_x(ax_n), .act_y(ay_n), .line_start(ls_n), .frame_start(fs_n)
    );

    initial begin
        pix_clk = 1'b0;
        forever #5 pix_clk = ~pix_clk;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: outputs for linear raster position pos (0 .. FRAME-1), positive polarity
    function automatic obs_t ref_out(input int pos);
        obs_t o;
        int   h, v;
        logic ha, va;
        h    = pos % T_HTOT;
        v    = pos / T_HTOT;
        ha   = (h >= T_HSYNC + T_HBP) && (h < T_HSYNC + T_HBP + T_HACT);
        va   = (v >= T_VSYNC + T_VBP) && (v < T_VSYNC + T_VBP + T_VACT);
        o.hs = (h < T_HSYNC);
        o.vs = (v < T_VSYNC);
        o.de = ha && va;
        o.ls = (h == 0);
        o.fs = (pos == 0);
        o.ax = o.de ? 13'(h - (T_HSYNC + T_HBP)) : 13'(0);
        o.ay = o.de ? 13'(v - (T_VSYNC + T_VBP)) : 13'(0);
        return o;
    endfunction

    function automatic obs_t to_neg(input obs_t o);
        obs_t r;
        r    = o;
        r.hs = ~o.hs;
        r.vs = ~o.vs;
        return r;
    endfunction

    function automatic obs_t mk(input logic hs, input logic vs, input logic de,
                                input logic ls, input logic fs, input int ax, input int ay);
        obs_t o;
        o.hs = hs; o.vs = vs; o.de = de; o.ls = ls; o.fs = fs;
        o.ax = 13'(ax);
        o.ay = 13'(ay);
        return o;
    endfunction

    function automatic obs_t obs_p();
        return mk(hs_p, vs_p, de_p, ls_p, fs_p, int'(ax_p), int'(ay_p));
    endfunction

    function automatic obs_t obs_n();
        return mk(hs_n, vs_n, de_n, ls_n, fs_n, int'(ax_n), int'(ay_n));
    endfunction

    task automatic cmp(input string name, input obs_t act, input obs_t exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d, want hs=%b vs=%b de=%b ls=%b fs=%b x=%0d y=%0d",
                     name, $time, act.hs, act.vs, act.de, act.ls, act.fs, act.ax, act.ay,
                     exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.ax, exp.ay);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s @%0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input string n, input int c, input obs_t e);
        vecs[i].name = n;
        vecs[i].cyc  = c;
        vecs[i].exp  = e;
    endtask

    task automatic do_reset(input int n);
        @(negedge pix_clk);
        rst = 1'b1;
        repeat (n) @(negedge pix_clk);
        rst = 1'b0;
    endtask

    // Called right after reset release: checks the start of a fresh frame
    task automatic check_restart(input string tag);
        int k;
        int hs_run;
        @(posedge pix_clk); #1;
        k = 1;
        cmp_int({tag, "_fs_k1"}, int'(fs_p), 1);
        hs_run = 0;
        while (hs_p === 1'b1 && hs_run < T_HTOT) begin
            hs_run++;
            @(posedge pix_clk); #1;
            k++;
        end
        cmp_int({tag, "_hs_len"}, hs_run, T_HSYNC);
        while (de_p !== 1'b1 && k < 2 * FRAME) begin
            @(posedge pix_clk); #1;
            k++;
        end
        cmp_int({tag, "_de_cycle"}, k, (T_VSYNC + T_VBP) * T_HTOT + T_HSYNC + T_HBP + 1);
        cmp_int({tag, "_de_x0"}, int'(ax_p), 0);
        cmp_int({tag, "_de_y0"}, int'(ay_p), 0);
    endtask

    // Cycle-by-cycle monitor against the reference, both polarities
    initial begin
        obs_t e;
        forever begin
            @(posedge pix_clk);
            if (rst === 1'b1) begin
                e    = '0;
                mpos = 0;
            end else begin
                e    = ref_out(mpos);
                mpos = (mpos + 1) % FRAME;
            end
            #1;
            cmp("mon", obs_p(), e);
            cmp("mon_n", obs_n(), to_neg(e));
        end
    end

    initial begin
        int de_len, ax_bad, w, period, vs_cnt, hs_cnt, de_cnt, last_ay;
        rst = 1'b1;

        // Sample k (edges after release) shows raster position k-1
        set_vec(0,  "fs_k1",     1,   mk(1, 1, 0, 1, 1, 0, 0));
        set_vec(1,  "k2",        2,   mk(1, 1, 0, 0, 0, 0, 0));
        set_vec(2,  "hs_last",   4,   mk(1, 1, 0, 0, 0, 0, 0));
        set_vec(3,  "hs_fall",   5,   mk(0, 1, 0, 0, 0, 0, 0));
        set_vec(4,  "line1",     29,  mk(1, 1, 0, 1, 0, 0, 0));
        set_vec(5,  "vs_fall",   57,  mk(1, 0, 0, 1, 0, 0, 0));
        set_vec(6,  "pre_de",    149, mk(0, 0, 0, 0, 0, 0, 0));
        set_vec(7,  "de_first",  150, mk(0, 0, 1, 0, 0, 0, 0));
        set_vec(8,  "de_last_x", 165, mk(0, 0, 1, 0, 0, 15, 0));
        set_vec(9,  "de_fall",   166, mk(0, 0, 0, 0, 0, 0, 0));
        set_vec(10, "de_last_y", 305, mk(0, 0, 1, 0, 0, 15, 5));
        set_vec(11, "vfp",       318, mk(0, 0, 0, 0, 0, 0, 0));
        set_vec(12, "frame_end", 364, mk(0, 0, 0, 0, 0, 0, 0));
        set_vec(13, "fs_wrap",   365, mk(1, 1, 0, 1, 1, 0, 0));

        // Idle while held in reset
        repeat (3) begin
            @(posedge pix_clk); #1;
            cmp("rst_hold", obs_p(), '0);
            cmp("rst_hold_n", obs_n(), to_neg('0));
        end

        // Table vectors, each from a fresh reset
        for (int i = 0; i < 14; i++) begin
            do_reset(2);
            repeat (vecs[i].cyc) @(posedge pix_clk);
            #1;
            cmp(vecs[i].name, obs_p(), vecs[i].exp);
            cmp({vecs[i].name, "_n"}, obs_n(), to_neg(vecs[i].exp));
        end

        // Restart behaviour, then one full active line
        do_reset(2);
        check_restart("boot");
        de_len = 0;
        ax_bad = 0;
        while (de_p === 1'b1 && de_len < 2 * T_HTOT) begin
            if (int'(ax_p) != de_len) ax_bad++;
            de_len++;
            @(posedge pix_clk); #1;
        end
        cmp_int("line_de_len", de_len, T_HACT);
        cmp_int("line_ax_seq_errs", ax_bad, 0);
        cmp_int("line_ax_after", int'(ax_p), 0);

        // One whole frame between frame_start pulses
        w = 0;
        while (fs_p !== 1'b1 && w < 2 * FRAME) begin
            @(posedge pix_clk); #1;
            w++;
        end
        cmp_int("frame_found", int'(fs_p), 1);
        period = 0; vs_cnt = 0; hs_cnt = 0; de_cnt = 0; last_ay = -1;
        do begin
            if (vs_p === 1'b1) vs_cnt++;
            if (hs_p === 1'b1) hs_cnt++;
            if (de_p === 1'b1) begin
                de_cnt++;
                last_ay = int'(ay_p);
            end
            period++;
            @(posedge pix_clk); #1;
        end while (fs_p !== 1'b1 && period < 2 * FRAME);
        cmp_int("frame_period", period, FRAME);
        cmp_int("frame_vs_cycles", vs_cnt, T_VSYNC * T_HTOT);
        cmp_int("frame_hs_cycles", hs_cnt, T_HSYNC * T_VTOT);
        cmp_int("frame_de_cycles", de_cnt, T_HACT * T_VACT);
        cmp_int("frame_last_ay", last_ay, T_VACT - 1);

        // Reset pulsed mid-frame (line 8, pixel 20), then a clean restart
        do_reset(2);
        repeat (8 * T_HTOT + 20 + 1) @(posedge pix_clk);
        #1;
        cmp("mid_pos", obs_p(), mk(0, 0, 1, 0, 0, 11, 3));
        @(negedge pix_clk);
        rst = 1'b1;
        repeat (3) begin
            @(posedge pix_clk); #1;
            cmp("mid_rst_idle", obs_p(), '0);
            cmp("mid_rst_idle_n", obs_n(), to_neg('0));
        end
        @(negedge pix_clk);
        rst = 1'b0;
        check_restart("restart");

        // Random run lengths with random reset pulses, checked by the monitor
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(1, 300)) @(negedge pix_clk);
            if ($urandom_range(0, 2) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge pix_clk);
                rst = 1'b0;
            end
        end
        @(posedge pix_clk); #2;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
